// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, status flags and the multiplier FSM states.
// Every initiator that drives alu_64 imports this package.
package alu_pkg;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        SUM  = 3'd1,
        SUB  = 3'd2,
        AND  = 3'd3,
        XOR  = 3'd4,
        NOT  = 3'd5,
        INC  = 3'd6
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq_64_if.sv
// Request/response bundle between an issuing stage and mul_seq_64.
interface mul_seq_64_if;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        zero;

    modport master (output start, a, b, input busy, done, product, zero);
    modport slave  (input start, a, b, output busy, done, product, zero);
endinterface

// File: rtl/alu_64.sv
// Combinational 64-bit ALU; a passive responder that computes result and flags for funct.
module alu_64
    import alu_pkg::*;
(
    input  alu_op_t     funct,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result,
    output alu_flags_t  flags
);

    logic [64:0] wide;

    always_comb begin
        wide           = '0;
        flags.overflow = 1'b0;
        unique case (funct)
            LOAD: wide = {1'b0, b};
            SUM: begin
                wide           = {1'b0, a} + {1'b0, b};
                flags.overflow = (a[63] == b[63]) && (wide[63] != a[63]);
            end
            SUB: begin
                // bit 64 carries the borrow out of the subtraction
                wide           = {1'b0, a} - {1'b0, b};
                flags.overflow = (a[63] != b[63]) && (wide[63] != a[63]);
            end
            AND: wide = {1'b0, a & b};
            XOR: wide = {1'b0, a ^ b};
            NOT: wide = {1'b0, ~a};
            INC: begin
                wide           = {1'b0, a} + 65'd1;
                flags.overflow = !a[63] && wide[63];
            end
            default: wide = '0;
        endcase
        result         = wide[63:0];
        flags.carry    = wide[64];
        flags.zero     = (wide[63:0] == 64'd0);
        flags.negative = wide[63];
    end

endmodule

// File: rtl/mul_seq_64.sv
// Sequential shift-add multiplier returning the low 64 bits of a*b.
// One SUM per cycle through alu_64; signed operands need no correction modulo 2^64.
module mul_seq_64
    import alu_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    mul_seq_64_if.slave   bus
);

    mul_state_t  state_q, state_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] product_q, product_d;
    logic        zero_q, zero_d;
    logic        load_result;

    logic [63:0] alu_result;
    alu_flags_t  alu_flags_unused;

    alu_64 u_alu (
        .funct  (SUM),
        .a      (acc_q),
        .b      (mcand_q),
        .result (alu_result),
        .flags  (alu_flags_unused)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = (EARLY_EXIT && (bus.b == 64'd0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 7'd1;
                if ((cnt_q == 7'd63) || (EARLY_EXIT && (mplier_d == 64'd0))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result registers capture the final accumulator only on DONE entry
        load_result = (state_d == DONE) && (state_q != DONE);
        product_d   = load_result ? acc_d : product_q;
        zero_d      = load_result ? (acc_d == 64'd0) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
    assign bus.zero    = zero_q;

endmodule

// File: tb/tb_mul_seq_64.sv
// Directed-vector bench for mul_seq_64: results, done latency, busy timing, ignored start, reset.
module tb_mul_seq_64;

    logic        clk;
    logic        reset;
    logic        start;
    logic        dut_sel;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        busy_s;
    logic        done_s;
    logic [63:0] product_s;
    logic        zero_s;
    int          n_vec;
    int          n_err;

    mul_seq_64_if bus0 ();
    mul_seq_64_if bus1 ();

    assign bus0.start = start & ~dut_sel;
    assign bus0.a     = op_a;
    assign bus0.b     = op_b;
    assign bus1.start = start & dut_sel;
    assign bus1.a     = op_a;
    assign bus1.b     = op_b;

    assign busy_s    = dut_sel ? bus1.busy    : bus0.busy;
    assign done_s    = dut_sel ? bus1.done    : bus0.done;
    assign product_s = dut_sel ? bus1.product : bus0.product;
    assign zero_s    = dut_sel ? bus1.zero    : bus0.zero;

    mul_seq_64 #(.EARLY_EXIT(1'b1)) u_dut_ee (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mul_seq_64 #(.EARLY_EXIT(1'b0)) u_dut_full (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation; t+k is the cycle k after the edge that samples start.
    task automatic run_op(input string tag, input logic sel, input logic [63:0] av,
                          input logic [63:0] bv, input logic [63:0] exp_p,
                          input int exp_lat, input bit poke);
        int lat;
        int pulses;
        lat    = -1;
        pulses = 0;
        dut_sel = sel;
        op_a    = av;
        op_b    = bv;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ":busy_t1"}, 64'(busy_s), 64'd1);
        for (int k = 1; k <= 90; k++) begin
            if (poke && k == 3) begin
                op_a  = 64'd7;
                op_b  = 64'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_s) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (lat >= 0 && k == lat + 1) begin
                check({tag, ":busy_after"}, 64'(busy_s), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ":product"}, product_s, exp_p);
        check({tag, ":zero"}, 64'(zero_s), 64'(exp_p == 64'd0));
        check({tag, ":pulses"}, 64'(pulses), 64'd1);
        $display("op %s a=%h b=%h product=%h zero=%0d latency=%0d pulses=%0d",
                 tag, av, bv, product_s, zero_s, lat, pulses);
    endtask

    initial begin
        int pulses;
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        dut_sel = 1'b0;
        op_a    = '0;
        op_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst:busy0", 64'(bus0.busy), 64'd0);
        check("rst:done0", 64'(bus0.done), 64'd0);
        check("rst:prod0", bus0.product, 64'd0);
        check("rst:zero0", 64'(bus0.zero), 64'd1);
        check("rst:busy1", 64'(bus1.busy), 64'd0);
        check("rst:zero1", 64'(bus1.zero), 64'd1);
        $display("op reset busy=%0d done=%0d product=%h zero=%0d",
                 bus0.busy, bus0.done, bus0.product, bus0.zero);

        run_op("12x25",   1'b0, 64'd12, 64'd25, 64'd300, 6, 1'b0);
        run_op("m3x5",    1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
               64'hFFFF_FFFF_FFFF_FFF1, 4, 1'b0);
        run_op("5xm3",    1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFF1, 65, 1'b0);
        run_op("wrap",    1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3,
               64'h7FFF_FFFF_FFFF_FFFD, 3, 1'b0);
        run_op("123x0",   1'b0, 64'd123, 64'd0, 64'd0, 1, 1'b0);
        run_op("full2x1", 1'b1, 64'd2, 64'd1, 64'd2, 65, 1'b0);
        run_op("poke",    1'b0, 64'd11, 64'h100, 64'd2816, 10, 1'b1);

        // Reset in the middle of a long operation
        dut_sel = 1'b0;
        op_a    = 64'd5;
        op_b    = 64'hFFFF_FFFF_FFFF_FFFD;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst:busy", 64'(busy_s), 64'd0);
        check("midrst:done", 64'(done_s), 64'd0);
        check("midrst:prod", product_s, 64'd0);
        check("midrst:zero", 64'(zero_s), 64'd1);
        pulses = 0;
        for (int k = 0; k < 70; k++) begin
            if (done_s) pulses++;
            @(posedge clk);
            #1;
        end
        check("midrst:nodone", 64'(pulses), 64'd0);
        $display("op midrst busy=%0d product=%h zero=%0d late_done=%0d",
                 busy_s, product_s, zero_s, pulses);

        run_op("6x7", 1'b0, 64'd6, 64'd7, 64'd42, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq_64.md
# mul_seq_64

Sequential 64-bit shift-add multiplier that drives an `alu_64` instance as its datapath, issuing one `SUM` operation per cycle. It returns the low 64 bits of the two's-complement product a × b. The ALU is a passive responder; this block is the first initiator that sequences operations into it. It sits beside the ALU in the execute stage and serves multiply instructions that the single-cycle ALU cannot complete.

## Interface
- `EARLY_EXIT`, default 1: 1 ends iteration once the remaining multiplier bits are all zero; 0 always runs 64 iterations.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  64  multiplicand, signed two's complement; sampled with `start`.
- `b`  input  64  multiplier, signed two's complement; sampled with `start`.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  single-cycle pulse; `product` is valid.
- `product`  output  64  low 64 bits of a × b; held until the next accepted `start`.
- `zero`  output  1  `product == 0`; registered with `product`.

## Operation
- Registers:
  - `mcand` (64): shifts left 1 per iteration; bits shifted out are discarded.
  - `mplier` (64): logical shift right 1 per iteration.
  - `acc` (64).
  - `cnt` (7).
- ALU drive: `funct = SUM`, `a = acc`, `b = mcand`, held constant in every state.
  - `acc <= alu.result` only when `mplier[0] == 1` in RUN.
  - ALU status flags are ignored. Overflow of the low 64 bits wraps silently.
- States:
  - IDLE, on `start`:
    - `mcand <= a`, `mplier <= b`, `acc <= 0`, `cnt <= 0`.
    - If `b == 0` and `EARLY_EXIT == 1`, go to DONE; otherwise go to RUN.
  - RUN, each cycle:
    - Conditional accumulate.
    - `mcand <= mcand << 1`, `mplier <= mplier >> 1`, `cnt <= cnt + 1`.
    - Leave for DONE when `cnt == 63`, or when `EARLY_EXIT` is set and `(mplier >> 1) == 0`.
  - DONE (1 cycle):
    - `done = 1`; `product` and `zero` are loaded from the final `acc` on entry.
    - Return to IDLE unconditionally.
- Signed operands need no correction. The low 64 bits of the unsigned product equal the low 64 bits of the signed product.
- `start` is ignored in RUN and DONE; there is no queueing.
- Reset (at any time, including mid-RUN):
  - State goes to IDLE.
  - `busy = 0`, `done = 0`, `product = 0`, `zero = 1`, `acc = 0`.
  - The in-flight operation is discarded.

## Timing
- `start` is sampled at edge t.
- RUN occupies cycles t+1 … t+n.
  - `EARLY_EXIT = 1`: n = (index of highest set bit of b) + 1. For b < 0, n = 64.
  - `EARLY_EXIT = 0`: n = 64.
- `done` is high in cycle t+n+1, with `product` and `zero` valid in that cycle.
- Case b = 0 with early exit: `done` is high in cycle t+1.
- `busy` rises in cycle t+1 and falls in the cycle after `done`.
- Earliest next accepted `start`: the edge ending the cycle after `done`, since IDLE must be re-entered first.
- `product` and `zero` only change on DONE entry or on reset.

## Structure
- Shared package `alu_pkg` holds:
  - The ALU op encoding: LOAD=0, SUM=1, SUB=2, AND=3, XOR=4, NOT=5, INC=6, as a 3-bit typedef `alu_op_t`.
  - The state typedef `mul_state_t {IDLE, RUN, DONE}`.
- The existing ALU bench and all future initiators import `alu_pkg` rather than redeclaring the enum.
- One sub-module: `alu_64`, instantiated once as the adder.
- All control is a single FSM plus datapath registers in `mul_seq_64`.

## Test plan
- a=12, b=25, `EARLY_EXIT`=1:
  - `product` = 300, `zero` = 0.
  - `done` in cycle t+6 (b has highest set bit 4, so n = 5).
- a=-3, b=5: `product` = -15 (0xFFFF_FFFF_FFFF_FFF1); a=5, b=-3: `product` = -15 with n = 64, `done` in cycle t+65.
- a=0x7FFF_FFFF_FFFF_FFFF, b=3: `product` = 0x7FFF_FFFF_FFFF_FFFD (wrap). a=123, b=0: `product` = 0, `zero` = 1, `done` in cycle t+1.
- `EARLY_EXIT`=0, a=2, b=1: `product` = 2, `done` in cycle t+65.
- `start` pulsed mid-RUN with a=7, b=7: ignored. The original result completes unchanged and `done` pulses exactly once.
- `reset` asserted mid-RUN:
  - Next cycle: `busy` = 0, `product` = 0, `zero` = 1, and no `done` pulse.
  - A subsequent `start` with a=6, b=7 yields `product` = 42.
